decode_issue_stage: RTL and testbench

Parametrised successor to the processor's decode stage. Holds the register file, performs source-operand read with optional write-back bypass, and detects load-use hazards. Drives an ID/EX pipeline register through a valid/ready handshake, with flush and stall support. Sits between the fetch buffer (upstream) and the execute stage (downstream); the control unit's decoded bundle passes through it as an opaque payload.

---
 rtl/decode_issue_pkg.sv | 21 ++
 rtl/decode_issue_stage_regfile.sv | 39 +++
 rtl/decode_issue_stage.sv | 135 +++++++++++++
 tb/tb_decode_issue_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_pkg.sv
// Shared constants and the ID/EX payload type for the decode/issue stage.
package decode_issue_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int NUM_REGS_DEF    = 8;
    localparam int REG_AW_DEF      = $clog2(NUM_REGS_DEF);
    localparam int PC_W_DEF        = 32;
    localparam int CTRL_W_DEF      = 32;
    localparam int STALL_CNT_W_DEF = 16;

    localparam logic [STALL_CNT_W_DEF-1:0] STALL_CNT_MAX = '1;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] op1;
        logic [DATA_W_DEF-1:0] op2;
        logic [REG_AW_DEF-1:0] rd;
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [PC_W_DEF-1:0]   pc;
    } id_ex_t;

endpackage

// File: rtl/decode_issue_stage_regfile.sv
// Register file: one synchronous write port, two combinational read ports.
// DECODE_WB_BYPASS_EN makes a same-cycle write visible on the read ports.
module regfile_bypass #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int AW       = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr1_i,
    input  logic [AW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
    assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];
`else
    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];
`endif

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: operand read, load-use stall, ID/EX register with valid/ready.
// Write-back bypass on the register file is enabled by DECODE_WB_BYPASS_EN.
module decode_issue_stage
    import decode_issue_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int PC_W        = PC_W_DEF,
    parameter int CTRL_W      = CTRL_W_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF,
    localparam int REG_AW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [REG_AW-1:0]      in_rs1_i,
    input  logic [REG_AW-1:0]      in_rs2_i,
    input  logic                   in_uses_rs1_i,
    input  logic                   in_uses_rs2_i,
    input  logic [REG_AW-1:0]      in_rd_i,
    input  logic [CTRL_W-1:0]      in_ctrl_i,
    input  logic [PC_W-1:0]        in_pc_i,
    input  logic                   ex_mem_read_i,
    input  logic [REG_AW-1:0]      ex_rd_i,
    input  logic                   wb_we_i,
    input  logic [REG_AW-1:0]      wb_addr_i,
    input  logic [DATA_W-1:0]      wb_data_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_W-1:0]      out_op1_o,
    output logic [DATA_W-1:0]      out_op2_o,
    output logic [REG_AW-1:0]      out_rd_o,
    output logic [CTRL_W-1:0]      out_ctrl_o,
    output logic [PC_W-1:0]        out_pc_o,
    output logic                   hazard_stall_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o
);

    logic [DATA_W-1:0]      rdata1, rdata2;
    logic                   hazard, advance, accept;

    logic                   valid_q, valid_d;
    logic [DATA_W-1:0]      op1_q, op1_d, op2_q, op2_d;
    logic [REG_AW-1:0]      rd_q, rd_d;
    logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .AW       (REG_AW)
    ) u_regfile (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .we_i     (wb_we_i),
        .waddr_i  (wb_addr_i),
        .wdata_i  (wb_data_i),
        .raddr1_i (in_rs1_i),
        .raddr2_i (in_rs2_i),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    // A load in EX cannot forward in time; hold the consumer in ID for a cycle.
    assign hazard  = in_valid_i & ex_mem_read_i &
                     ((in_uses_rs1_i & (in_rs1_i == ex_rd_i)) |
                      (in_uses_rs2_i & (in_rs2_i == ex_rd_i)));
    assign advance = ~valid_q | out_ready_i;
    assign in_ready_o = advance & ~hazard & ~flush_i;
    assign accept  = in_valid_i & in_ready_o;

    always_comb begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            rd_d    = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            op1_d   = rdata1;
            op2_d   = rdata2;
            rd_d    = in_rd_i;
            ctrl_d  = in_ctrl_i;
            pc_d    = in_pc_i;
        end else if (advance) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q     <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o    = valid_q;
    assign out_op1_o      = op1_q;
    assign out_op2_o      = op2_q;
    assign out_rd_o       = rd_q;
    assign out_ctrl_o     = ctrl_q;
    assign out_pc_o       = pc_q;
    assign hazard_stall_o = hazard;
    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: hazard vector table plus scoreboarded issue sequences.
module tb_decode_issue_stage;
    import decode_issue_pkg::*;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;
    localparam int PW = 32;
    localparam int CW = 32;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [AW-1:0] in_rs1, in_rs2, in_rd, ex_rd, wb_addr, out_rd;
    logic          in_uses_rs1, in_uses_rs2, ex_mem_read, wb_we, flush;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [PW-1:0] in_pc, out_pc;
    logic [DW-1:0] wb_data, out_op1, out_op2;
    logic          out_valid, out_ready, hazard_stall;
    logic [SW-1:0] stall_cycles;

    always #5 clk = ~clk;

    decode_issue_stage #(
        .DATA_W(DW), .NUM_REGS(NR), .PC_W(PW), .CTRL_W(CW), .STALL_CNT_W(SW)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_rs1_i(in_rs1), .in_rs2_i(in_rs2),
        .in_uses_rs1_i(in_uses_rs1), .in_uses_rs2_i(in_uses_rs2),
        .in_rd_i(in_rd), .in_ctrl_i(in_ctrl), .in_pc_i(in_pc),
        .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd),
        .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_op1_o(out_op1), .out_op2_o(out_op2), .out_rd_o(out_rd),
        .out_ctrl_o(out_ctrl), .out_pc_o(out_pc),
        .hazard_stall_o(hazard_stall), .stall_cycles_o(stall_cycles)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            exp_stall = 0;
    id_ex_t        sb [$];
    id_ex_t        mon_e;
    logic [DW-1:0] ref_rf [NR];
    logic [DW-1:0] old_val, a_op1;

    typedef struct {
        logic          ld;
        logic [AW-1:0] ex_rd;
        logic [AW-1:0] rs1;
        logic          u1;
        logic [AW-1:0] rs2;
        logic          u2;
        logic          v;
        logic          fl;
        logic          haz;
        logic          rdy;
    } hvec_t;
    hvec_t hv [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
`ifdef DECODE_WB_BYPASS_EN
        if (wb_we && (wb_addr == a)) return wb_data;
`endif
        return ref_rf[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NR; i++) ref_rf[i] = '0;
        end else if (wb_we) begin
            ref_rf[wb_addr] = wb_data;
        end
        #1;
    endtask

    task automatic drive_idle();
        reset = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_ctrl = '0; in_pc = '0;
        ex_mem_read = 1'b0; ex_rd = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic u1, input logic [AW-1:0] rs2,
                         input logic u2, input logic [AW-1:0] rd, input logic [CW-1:0] ctrl,
                         input logic [PW-1:0] pc);
        drive_idle();
        in_valid = 1'b1; in_rs1 = rs1; in_uses_rs1 = u1; in_rs2 = rs2; in_uses_rs2 = u2;
        in_rd = rd; in_ctrl = ctrl; in_pc = pc;
    endtask

    task automatic push_exp();
        id_ex_t e;
        e.op1 = model_rd(in_rs1); e.op2 = model_rd(in_rs2);
        e.rd = in_rd; e.ctrl = in_ctrl; e.pc = in_pc;
        sb.push_back(e);
    endtask

    // Every transfer EX takes is compared against the oldest expected payload.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_op1", out_op1, mon_e.op1);
                check("sb_op2", out_op2, mon_e.op2);
                check("sb_rd", out_rd, mon_e.rd);
                check("sb_ctrl", out_ctrl, mon_e.ctrl);
                check("sb_pc", out_pc, mon_e.pc);
            end
        end
    end

    initial begin
        //            ld    ex_rd  rs1    u1    rs2    u2    v     fl    haz   rdy
        hv[0] = '{1'b1, 3'd2, 3'd0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        hv[1] = '{1'b1, 3'd2, 3'd0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        hv[2] = '{1'b1, 3'd4, 3'd4, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        hv[3] = '{1'b0, 3'd4, 3'd4, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        hv[4] = '{1'b1, 3'd4, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        hv[5] = '{1'b1, 3'd6, 3'd5, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        hv[6] = '{1'b0, 3'd0, 3'd1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        hv[7] = '{1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < NR; i++) ref_rf[i] = '0;
        drive_idle();
        reset = 1'b1;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_op1", out_op1, 0);
        check("rst_out_op2", out_op2, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        drive_idle();
        #1 check("rst_in_ready", in_ready, 1);

        // Write R3, then fill the rest of the file with distinct values.
        wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
        tick();
        for (int i = 1; i < NR; i++) begin
            if (i != 3) begin
                wb_we = 1'b1; wb_addr = AW'(i); wb_data = DW'(16'h1000 + i * 16'h0111);
                tick();
            end
        end
        issue(3'd3, 1'b1, 3'd6, 1'b1, 3'd1, 32'hA5A5_0001, 32'h100);
        push_exp();
        #1 check("first_in_ready", in_ready, 1);
        tick();
        check("first_out_valid", out_valid, 1);
        check("first_out_op1", out_op1, 16'h1234);
        drive_idle();
        tick();
        check("first_bubble_valid", out_valid, 0);
        check("first_bubble_ctrl", out_ctrl, 0);

        // Hazard/in_ready truth table with an empty ID/EX register.
        for (int i = 0; i < 8; i++) begin
            drive_idle();
            ex_mem_read = hv[i].ld; ex_rd = hv[i].ex_rd; in_valid = hv[i].v;
            in_rs1 = hv[i].rs1; in_uses_rs1 = hv[i].u1;
            in_rs2 = hv[i].rs2; in_uses_rs2 = hv[i].u2;
            in_rd = AW'(i); in_ctrl = 32'hC0DE_0000 + i; in_pc = 32'h200 + i;
            flush = hv[i].fl;
            #1;
            check($sformatf("hazard_v%0d", i), hazard_stall, hv[i].haz);
            check($sformatf("in_ready_v%0d", i), in_ready, hv[i].rdy);
            if (hv[i].v && hv[i].rdy) push_exp();
            if (hv[i].haz) exp_stall++;
            tick();
            drive_idle();
            tick();
        end
        check("table_stall_cycles", stall_cycles, exp_stall);

        // Load-use: bubble behind a valid instruction, then accept once the load clears.
        issue(3'd1, 1'b1, 3'd0, 1'b0, 3'd3, 32'hB0, 32'h300);
        push_exp();
        tick();
        issue(3'd0, 1'b0, 3'd2, 1'b1, 3'd4, 32'hB1, 32'h301);
        ex_mem_read = 1'b1; ex_rd = 3'd2;
        #1;
        check("lu_hazard", hazard_stall, 1);
        check("lu_in_ready", in_ready, 0);
        exp_stall++;
        tick();
        check("lu_bubble", out_valid, 0);
        check("lu_stall_cycles", stall_cycles, exp_stall);
        ex_mem_read = 1'b0;
        #1 check("lu_release_ready", in_ready, 1);
        push_exp();
        tick();
        check("lu_accept_valid", out_valid, 1);
        check("lu_accept_pc", out_pc, 32'h301);
        drive_idle();
        tick();

        // Backpressure: three held cycles, then exactly one release.
        issue(3'd2, 1'b1, 3'd4, 1'b1, 3'd5, 32'hBB01, 32'h400);
        push_exp();
        a_op1 = model_rd(3'd2);
        tick();
        issue(3'd7, 1'b1, 3'd1, 1'b1, 3'd6, 32'hBB02, 32'h401);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_in_ready", in_ready, 0);
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_pc", out_pc, 32'h400);
            check("bp_ctrl", out_ctrl, 32'hBB01);
            check("bp_op1", out_op1, a_op1);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", in_ready, 1);
        push_exp();
        tick();
        check("bp_next_valid", out_valid, 1);
        check("bp_next_pc", out_pc, 32'h401);
        drive_idle();
        tick();
        check("bp_drained", out_valid, 0);
        check("bp_one_released", sb.size(), 0);

        // Flush squashes the held instruction and refuses the incoming one.
        issue(3'd3, 1'b1, 3'd0, 1'b0, 3'd2, 32'hF1, 32'h500);
        out_ready = 1'b0;
        push_exp();
        tick();
        check("fl_pre_valid", out_valid, 1);
        issue(3'd4, 1'b1, 3'd0, 1'b0, 3'd3, 32'hF2, 32'h501);
        out_ready = 1'b0; flush = 1'b1;
        #1 check("fl_in_ready", in_ready, 0);
        tick();
        check("fl_valid", out_valid, 0);
        check("fl_ctrl", out_ctrl, 0);
        check("fl_rd", out_rd, 0);
        void'(sb.pop_front());
        drive_idle();
        tick();
        check("fl_not_accepted", out_valid, 0);
        check("fl_stall_kept", stall_cycles, exp_stall);

        // Same-cycle write-back and read of R5.
        old_val = ref_rf[5];
        issue(3'd5, 1'b1, 3'd0, 1'b0, 3'd1, 32'hBE, 32'h600);
        wb_we = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
        push_exp();
        #1 check("byp_in_ready", in_ready, 1);
        tick();
`ifdef DECODE_WB_BYPASS_EN
        check("byp_op1", out_op1, 16'hBEEF);
`else
        check("byp_op1", out_op1, old_val);
`endif
        issue(3'd5, 1'b1, 3'd5, 1'b1, 3'd2, 32'hBF, 32'h601);
        push_exp();
        tick();
        check("byp_written_op1", out_op1, 16'hBEEF);
        drive_idle();
        tick();

        // Stall counter saturates rather than wrapping.
        issue(3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 32'h0, 32'h700);
        ex_mem_read = 1'b1; ex_rd = 3'd1;
        repeat (65535 - exp_stall + 3) @(posedge clk);
        #1;
        check("sat_stall_cycles", stall_cycles, STALL_CNT_MAX);
        check("sat_out_valid", out_valid, 0);
        drive_idle();
        tick();

        // Reset with an instruction held in ID/EX.
        issue(3'd6, 1'b1, 3'd0, 1'b0, 3'd7, 32'hDD, 32'h800);
        out_ready = 1'b0;
        push_exp();
        tick();
        check("mid_pre_valid", out_valid, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_pc", out_pc, 0);
        check("mid_rst_op1", out_op1, 0);
        check("mid_rst_stall", stall_cycles, 0);
        sb.delete();
        drive_idle();
        tick();
        issue(3'd6, 1'b1, 3'd0, 1'b0, 3'd1, 32'hEE, 32'h900);
        push_exp();
        tick();
        check("mid_rf_cleared", out_op1, 0);
        drive_idle();
        tick();
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
